// File: rtl/memory_wb_stage.sv
// rtl/memory_wb_stage.sv - Y86-64 memory stage with W pipeline register
//
// Purpose: performs the data-memory access selected by M_icode, produces the
// forwarded read data / status, and registers results into the W register.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   W_stall, W_bubble     W register hold / NOP insertion (stall wins)
//   M_stat, M_icode       status and instruction code from the M register
//   M_cnd                 condition flag (not used by this stage)
//   M_valE, M_valA        ALU result / address, store data / pop-ret address
//   M_dstE, M_dstM        destination registers
//   m_valM, m_stat        combinational read data and stage status
//   W_stat .. W_dstM      W register outputs feeding register-file writeback
module memory_wb_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        W_stall,
  input  logic        W_bubble,
  input  logic [2:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  output logic [63:0] m_valM,
  output logic [2:0]  m_stat,
  output logic [2:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd3;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  logic [7:0]    mem [0:MEM_BYTES-1];
  logic [63:0]   addr;
  logic          rd_en;
  logic          wr_en;
  logic          dmem_error;
  logic          wr_commit;
  logic [AW-1:0] base;

  // The condition flag only travels with the instruction for debug visibility.
  logic unused_ok;
  assign unused_ok = M_cnd;

  always_comb begin
    addr  = '0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    case (M_icode)
      I_RMMOVQ, I_PUSHQ, I_CALL: begin
        addr  = M_valE;
        wr_en = 1'b1;
      end
      I_MRMOVQ: begin
        addr  = M_valE;
        rd_en = 1'b1;
      end
      I_POPQ, I_RET: begin
        addr  = M_valA;
        rd_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Full-width compare: any address whose 8-byte span leaves memory faults,
  // including huge values that would wrap if only low bits were examined.
  assign dmem_error = (rd_en || wr_en) && (addr > 64'(MEM_BYTES - 8));
  assign base       = addr[AW-1:0];
  assign m_stat     = dmem_error ? STAT_ADR : M_stat;
  assign wr_commit  = wr_en && (M_stat == STAT_AOK) && !dmem_error;

  always_comb begin
    m_valM = '0;
    if (rd_en && !dmem_error) begin
      for (int i = 0; i < 8; i++) begin
        m_valM[8*i +: 8] = mem[base + AW'(i)];
      end
    end
  end

  // Memory has no reset; rst_n only gates the write so stores held during
  // reset (or on the edge where reset asserts) never land.
  always_ff @(posedge clk) begin
    if (rst_n && wr_commit) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= M_valA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      W_stat  <= STAT_AOK;
      W_icode <= I_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= R_NONE;
      W_dstM  <= R_NONE;
    end else if (W_stall) begin
      W_stat  <= W_stat;
      W_icode <= W_icode;
      W_valE  <= W_valE;
      W_valM  <= W_valM;
      W_dstE  <= W_dstE;
      W_dstM  <= W_dstM;
    end else if (W_bubble) begin
      W_stat  <= STAT_AOK;
      W_icode <= I_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= R_NONE;
      W_dstM  <= R_NONE;
    end else begin
      W_stat  <= m_stat;
      W_icode <= M_icode;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_dstE  <= M_dstE;
      W_dstM  <= M_dstM;
    end
  end

endmodule

// File: tb/tb_memory_wb_stage.sv
// tb/tb_memory_wb_stage.sv - self-checking bench for memory_wb_stage
module tb_memory_wb_stage;
  localparam int MB = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        W_stall, W_bubble, M_cnd;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode, M_dstE, M_dstM;
  logic [63:0] M_valE, M_valA;
  logic [63:0] m_valM, W_valE, W_valM;
  logic [2:0]  m_stat, W_stat;
  logic [3:0]  W_icode, W_dstE, W_dstM;

  always #5 clk = ~clk;

  memory_wb_stage #(.MEM_BYTES(MB)) dut (
    .clk(clk), .rst_n(rst_n), .W_stall(W_stall), .W_bubble(W_bubble),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM), .m_valM(m_valM),
    .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE),
    .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM)
  );

  typedef struct {
    logic        stall, bubble;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE, valA;
    logic [3:0]  dstE, dstM;
    logic [63:0] x_valM;
    logic [2:0]  x_mstat, x_wstat;
    logic [3:0]  x_wicode;
    logic [63:0] x_wvalE, x_wvalM;
    logic [3:0]  x_wdstE, x_wdstM;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mdl [MB];
  logic [2:0]  ew_stat;
  logic [3:0]  ew_icode, ew_dstE, ew_dstM;
  logic [63:0] ew_valE, ew_valM;
  vec_t        tbl [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic stall, input logic bubble, input logic [2:0] stat,
                              input logic [3:0] icode, input logic [63:0] valE, input logic [63:0] valA,
                              input logic [3:0] dstE, input logic [3:0] dstM,
                              input logic [63:0] x_valM, input logic [2:0] x_mstat,
                              input logic [2:0] x_wstat, input logic [3:0] x_wicode,
                              input logic [63:0] x_wvalE, input logic [63:0] x_wvalM,
                              input logic [3:0] x_wdstE, input logic [3:0] x_wdstM);
    vec_t v;
    v.stall = stall; v.bubble = bubble; v.stat = stat; v.icode = icode;
    v.valE = valE; v.valA = valA; v.dstE = dstE; v.dstM = dstM;
    v.x_valM = x_valM; v.x_mstat = x_mstat; v.x_wstat = x_wstat; v.x_wicode = x_wicode;
    v.x_wvalE = x_wvalE; v.x_wvalM = x_wvalM; v.x_wdstE = x_wdstE; v.x_wdstM = x_wdstM;
    return v;
  endfunction

  task automatic drive(input logic stall, input logic bubble, input logic [2:0] stat,
                       input logic [3:0] icode, input logic [63:0] valE, input logic [63:0] valA,
                       input logic [3:0] dstE, input logic [3:0] dstM);
    W_stall = stall; W_bubble = bubble; M_stat = stat; M_icode = icode;
    M_valE = valE; M_valA = valA; M_dstE = dstE; M_dstM = dstM;
    M_cnd = 1'($urandom_range(0, 1));
  endtask

  // Reference rules: which instructions touch memory and where.
  function automatic logic is_rd(input logic [3:0] ic);
    return ic == 4'h5 || ic == 4'hB || ic == 4'h9;
  endfunction
  function automatic logic is_wr(input logic [3:0] ic);
    return ic == 4'h4 || ic == 4'hA || ic == 4'h8;
  endfunction
  function automatic logic [63:0] ref_addr(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a);
    if (ic == 4'hB || ic == 4'h9) return a;
    if (is_rd(ic) || is_wr(ic)) return e;
    return 64'd0;
  endfunction
  function automatic logic ref_err(input logic [3:0] ic, input logic [63:0] ad);
    return (is_rd(ic) || is_wr(ic)) && (ad > 64'(MB - 8));
  endfunction
  function automatic logic [63:0] mdl_word(input logic [63:0] ad);
    logic [63:0] w = 0;
    for (int i = 0; i < 8; i++) w = w | (64'(mdl[int'(ad) + i]) << (8 * i));
    return w;
  endfunction
  function automatic logic [63:0] pat_word(input int k);
    logic [63:0] w = 0;
    for (int i = 0; i < 8; i++) w = w | (64'(8'(8 * k + i) ^ 8'h5A) << (8 * i));
    return w;
  endfunction

  // Apply the store rule to the reference memory for the currently driven inputs.
  task automatic model_commit();
    logic [63:0] ad;
    ad = ref_addr(M_icode, M_valE, M_valA);
    if (rst_n && is_wr(M_icode) && M_stat == 3'd1 && !ref_err(M_icode, ad))
      for (int i = 0; i < 8; i++) mdl[int'(ad) + i] = M_valA[8*i +: 8];
  endtask

  task automatic chk_w(input string tag);
    chk({tag, ".W_stat"},  64'(W_stat),  64'(ew_stat));
    chk({tag, ".W_icode"}, 64'(W_icode), 64'(ew_icode));
    chk({tag, ".W_valE"},  W_valE,       ew_valE);
    chk({tag, ".W_valM"},  W_valM,       ew_valM);
    chk({tag, ".W_dstE"},  64'(W_dstE),  64'(ew_dstE));
    chk({tag, ".W_dstM"},  64'(W_dstM),  64'(ew_dstM));
  endtask

  task automatic set_nop();
    ew_stat = 3'd1; ew_icode = 4'h1; ew_valE = 0; ew_valM = 0; ew_dstE = 4'hF; ew_dstM = 4'hF;
  endtask

  // One cycle against the reference model; called at posedge+1 with inputs driven.
  task automatic model_cycle(input string tag);
    logic [63:0] ad, xv;
    logic        er;
    logic [2:0]  xs;
    #3;
    ad = ref_addr(M_icode, M_valE, M_valA);
    er = ref_err(M_icode, ad);
    xv = (is_rd(M_icode) && !er) ? mdl_word(ad) : 64'd0;
    xs = er ? 3'd3 : M_stat;
    chk({tag, ".m_valM"}, m_valM, xv);
    chk({tag, ".m_stat"}, 64'(m_stat), 64'(xs));
    model_commit();
    if (!W_stall) begin
      if (W_bubble) set_nop();
      else begin
        ew_stat = xs; ew_icode = M_icode; ew_valE = M_valE; ew_valM = xv;
        ew_dstE = M_dstE; ew_dstM = M_dstM;
      end
    end
    @(posedge clk); #1;
    chk_w(tag);
  endtask

  function automatic logic [63:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return {$urandom, $urandom};
    return 64'($urandom_range(0, MB + 8));
  endfunction

  initial begin
    drive(0, 0, 3'd1, 4'h4, 64'h30, 64'hFFFF_FFFF_FFFF_FFFF, 4'h2, 4'h3);
    #2 rst_n = 1'b0;
    #1;
    set_nop();
    chk_w("reset_async");
    @(posedge clk); @(posedge clk); #1;
    chk_w("reset_held");
    rst_n = 1'b1;

    for (int k = 0; k < MB / 8; k++) begin
      drive(0, 0, 3'd1, 4'h4, 64'(8 * k), pat_word(k), 4'hF, 4'hF);
      model_commit();
      @(posedge clk); #1;
    end

    // Store held across reset must not land; reset assertion mid-cycle is immediate.
    drive(0, 0, 3'd1, 4'h4, 64'h30, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    set_nop();
    chk_w("reset_mid");
    @(posedge clk); @(posedge clk); #1;
    drive(0, 0, 3'd1, 4'h5, 64'h30, 64'h0, 4'hF, 4'h9);
    rst_n = 1'b1;
    #3 chk("reset_store_blocked", m_valM, 64'h6D6C_6F6E_6968_6B6A);
    @(posedge clk); #1;
    chk("release_W_valM", W_valM, 64'h6D6C_6F6E_6968_6B6A);
    chk("release_W_icode", 64'(W_icode), 64'h5);
    chk("release_W_dstM", 64'(W_dstM), 64'h9);

    tbl.push_back(mk(0,0,1,4'h4,64'h10,64'h1122334455667788,4'hF,4'hF, 0,1, 1,4'h4,64'h10,0,4'hF,4'hF));
    tbl.push_back(mk(0,0,1,4'h5,64'h10,0,4'hF,4'h3, 64'h1122334455667788,1, 1,4'h5,64'h10,64'h1122334455667788,4'hF,4'h3));
    tbl.push_back(mk(0,0,1,4'h5,64'h0F,0,4'hF,4'h2, 64'h2233445566778855,1, 1,4'h5,64'h0F,64'h2233445566778855,4'hF,4'h2));
    tbl.push_back(mk(0,0,1,4'h5,64'd1017,0,4'hF,4'h4, 0,3, 3,4'h5,64'd1017,0,4'hF,4'h4));
    tbl.push_back(mk(0,0,1,4'h5,64'hFFFFFFFFFFFFFFF8,0,4'hF,4'h4, 0,3, 3,4'h5,64'hFFFFFFFFFFFFFFF8,0,4'hF,4'h4));
    tbl.push_back(mk(0,0,1,4'hA,64'd1024,64'hDEAD,4'h4,4'hF, 0,3, 3,4'hA,64'd1024,0,4'h4,4'hF));
    tbl.push_back(mk(0,0,1,4'h5,64'h0,0,4'hF,4'h8, 64'h5D5C5F5E59585B5A,1, 1,4'h5,0,64'h5D5C5F5E59585B5A,4'hF,4'h8));
    tbl.push_back(mk(0,0,1,4'h5,64'd1016,0,4'hF,4'h6, 64'hA5A4A7A6A1A0A3A2,1, 1,4'h5,64'd1016,64'hA5A4A7A6A1A0A3A2,4'hF,4'h6));
    tbl.push_back(mk(0,0,1,4'h4,64'd1016,64'h0123456789ABCDEF,4'hF,4'hF, 0,1, 1,4'h4,64'd1016,0,4'hF,4'hF));
    tbl.push_back(mk(0,0,1,4'h5,64'd1016,0,4'hF,4'h7, 64'h0123456789ABCDEF,1, 1,4'h5,64'd1016,64'h0123456789ABCDEF,4'hF,4'h7));
    tbl.push_back(mk(0,0,1,4'hA,64'h40,64'hCAFEBABEDEADBEEF,4'h4,4'hF, 0,1, 1,4'hA,64'h40,0,4'h4,4'hF));
    tbl.push_back(mk(0,0,1,4'hB,64'h48,64'h40,4'h4,4'h5, 64'hCAFEBABEDEADBEEF,1, 1,4'hB,64'h48,64'hCAFEBABEDEADBEEF,4'h4,4'h5));
    tbl.push_back(mk(0,0,1,4'h8,64'h80,64'h1234,4'h4,4'hF, 0,1, 1,4'h8,64'h80,0,4'h4,4'hF));
    tbl.push_back(mk(0,0,1,4'h9,64'h88,64'h80,4'h4,4'hF, 64'h1234,1, 1,4'h9,64'h88,64'h1234,4'h4,4'hF));
    tbl.push_back(mk(0,0,4,4'h4,64'h20,64'hFFFFFFFFFFFFFFFF,4'hF,4'hF, 0,4, 4,4'h4,64'h20,0,4'hF,4'hF));
    tbl.push_back(mk(0,0,1,4'h5,64'h20,0,4'hF,4'h1, 64'h7D7C7F7E79787B7A,1, 1,4'h5,64'h20,64'h7D7C7F7E79787B7A,4'hF,4'h1));
    tbl.push_back(mk(0,0,1,4'h6,64'h55,64'h1,4'h2,4'hF, 0,1, 1,4'h6,64'h55,0,4'h2,4'hF));
    tbl.push_back(mk(1,0,2,4'h3,64'h99,0,4'h3,4'h3, 0,2, 1,4'h6,64'h55,0,4'h2,4'hF));
    tbl.push_back(mk(1,0,1,4'h5,64'h18,0,4'hF,4'h1, 64'h4544474641404342,1, 1,4'h6,64'h55,0,4'h2,4'hF));
    tbl.push_back(mk(1,1,1,4'h6,64'h77,0,4'h1,4'hF, 0,1, 1,4'h6,64'h55,0,4'h2,4'hF));
    tbl.push_back(mk(0,1,1,4'h6,64'h77,0,4'h1,4'hF, 0,1, 1,4'h1,0,0,4'hF,4'hF));
    tbl.push_back(mk(1,0,3,4'h9,64'h0,64'h2000,4'hF,4'hF, 0,3, 1,4'h1,0,0,4'hF,4'hF));

    foreach (tbl[n]) begin
      drive(tbl[n].stall, tbl[n].bubble, tbl[n].stat, tbl[n].icode,
            tbl[n].valE, tbl[n].valA, tbl[n].dstE, tbl[n].dstM);
      #3;
      chk($sformatf("vec%0d.m_valM", n), m_valM, tbl[n].x_valM);
      chk($sformatf("vec%0d.m_stat", n), 64'(m_stat), 64'(tbl[n].x_mstat));
      model_commit();
      @(posedge clk); #1;
      ew_stat = tbl[n].x_wstat; ew_icode = tbl[n].x_wicode;
      ew_valE = tbl[n].x_wvalE; ew_valM = tbl[n].x_wvalM;
      ew_dstE = tbl[n].x_wdstE; ew_dstM = tbl[n].x_wdstM;
      chk_w($sformatf("vec%0d", n));
    end

    for (int r = 0; r < 400; r++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : 3'd1,
            4'($urandom_range(0, 11)), rnd_val(), rnd_val(),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      model_cycle($sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
